muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Multi-cycle integer multiply/divide unit for the SimpleRISC execute stage, serving the MUL, DIV and MOD instructions. It feeds operands to the existing 32-bit ripple adder `add` once per cycle and consumes the adder's `sum` and `c_out` to iterate shift-add multiplication or restoring division. It uses a start/busy/done handshake so the pipeline can stall until the result is ready.

Parameters:
WIDTH, 32, operand/result width; only 32 is supported, which matches `add`.
ITER_W, 6, iteration counter width; must hold WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request pulse; accepted only when busy=0
op  input  2  00=MUL, 01=DIV, 10=MOD, 11=reserved (executes as MUL)
a  input  32  operand A (dividend or multiplicand), two's complement
b  input  32  operand B (divisor or multiplier), two's complement
busy  output  1  high from the edge after start is accepted until the edge that sets done
done  output  1  single-cycle result-valid pulse
result  output  32  registered result; held until the next accepted start
div_by_zero  output  1  pulses with done when DIV/MOD has b=0

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; busy=0, done=0, div_by_zero=0, result=0, counter=0.
  - Reset asserted mid-operation aborts the operation; no done pulse is produced.
- FSM states:
  - IDLE: start=1 latches op, operand magnitudes and result signs, counter=0 -> CALC, busy=1.
  - CALC: one iteration per edge; after the 32nd iteration (counter==31) -> FIX.
  - FIX: applies the sign correction, writes result, done=1, busy=0 -> IDLE.
- Latency: done is high in the cycle after the 34th rising edge counted from (and including) the edge that samples start. It stays high for exactly one cycle.
- start while busy=1 is ignored. start in the same cycle that done is high is accepted; back-to-back operation is legal.
- MUL:
  - Unsigned shift-add on raw operands; the low 32 bits equal the signed product low word.
  - Each iteration: if multiplier bit0=1, acc = acc + multiplicand (adder, c_in=0).
  - Then multiplicand <<= 1 and multiplier >>= 1. Overflow beyond 32 bits is discarded.
- DIV/MOD:
  - Restoring division on |a| and |b|.
  - Each iteration: rem = {rem[30:0], dq[31]}, dq <<= 1.
  - trial = rem + ~|b| with c_in=1. If c_out=1, rem = trial and dq[0]=1.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
  - Negation in FIX is ~x + 1.
- Boundaries:
  - 0x8000_0000 / 0xFFFF_FFFF gives quotient 0x8000_0000 and remainder 0 (wraps, no flag).
  - b=0 on DIV/MOD: the CALC state is skipped. IDLE goes straight to FIX, and done follows 2 edges after the start edge. result is 0xFFFF_FFFF for DIV and a for MOD; div_by_zero=1 with done.
  - div_by_zero is 0 for every MUL.

Optional Feature:
MULDIV_EARLY_EXIT_EN
- Defined:
  - MUL with a=0 or b=0, and DIV/MOD with a=0 (b≠0), bypass CALC. The unit goes IDLE -> FIX, result=0, and done follows 2 edges after start.
  - MUL also exits CALC early once the remaining multiplier bits are 0. done then follows 1 edge after that iteration.
- Undefined: every non-divide-by-zero operation takes the fixed 34-edge latency.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings: OP_MUL, OP_DIV, OP_MOD;
  - state encoding: ST_IDLE, ST_CALC, ST_FIX;
  - the constant DIV0_QUOT = 32'hFFFF_FFFF.
- One sub-module instance: the existing `add`, shared by the MUL accumulate and the DIV trial subtract through an operand mux.
- Sign fix-up reuses the same adder in FIX (~x, c_in=1); no second adder is instantiated.

Test Plan:
- MUL a=7, b=0xFFFF_FFFD (-3) -> result 0xFFFF_FFEB, done on edge 34, busy high for 33 cycles, div_by_zero=0.
- DIV a=0xFFFF_FFF9 (-7), b=2 -> 0xFFFF_FFFD (-3). MOD with the same operands -> 0xFFFF_FFFF (-1).
- DIV a=100, b=0 -> result 0xFFFF_FFFF, div_by_zero=1, done 2 edges after start. MOD a=100, b=0 -> result 100 (0x64).
- DIV a=0x8000_0000, b=0xFFFF_FFFF -> result 0x8000_0000. MOD with the same operands -> 0.
- Start a MUL, assert reset at edge 10 -> busy=0, done=0, result=0 immediately. A new MUL 6*7 afterwards -> 42 (0x2A) with full latency.
- start pulsed again at edge 5 of a DIV 50/7 -> ignored, result 7. A start issued in the done cycle -> accepted, busy=1 on the next cycle.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the muldiv_unit multiply/divide datapath.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIV  = 2'b01,
    OP_MOD  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/add.sv
// Existing 32-bit adder of the SimpleRISC execute stage.
module add (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {32'b0, c_in};

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MUL/DIV/MOD unit iterating on the shared adder `add`.
// Optional macro MULDIV_EARLY_EXIT_EN: zero operands bypass CALC, MUL leaves CALC once the multiplier is exhausted.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ITER_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  state_e            state_r, state_nxt;
  op_e               op_r, op_nxt, start_op_s;
  logic [WIDTH-1:0]  acc_r, acc_nxt;
  logic [WIDTH-1:0]  x_r, x_nxt;
  logic [WIDTH-1:0]  y_r, y_nxt;
  logic [WIDTH-1:0]  result_r, result_nxt;
  logic [ITER_W-1:0] cnt_r, cnt_nxt;
  logic              neg_r, neg_nxt, bneg_r, bneg_nxt, dz_r, dz_nxt;
  logic              busy_r, busy_nxt, done_r, done_nxt, dz_out_r, dz_out_nxt;
  logic [WIDTH-1:0]  add_a_s, add_b_s, add_sum_s, rem_sh_s, fix_src_s;
  logic              add_cin_s, add_cout_s, is_div_s;

  assign start_op_s = (op == OP_DIV || op == OP_MOD) ? op_e'(op) : OP_MUL;
  assign is_div_s   = (op_r != OP_MUL);
  assign rem_sh_s   = {acc_r[WIDTH-2:0], x_r[WIDTH-1]};
  assign fix_src_s  = (op_r == OP_DIV) ? x_r : acc_r;

  add u_add (
    .a     (add_a_s),
    .b     (add_b_s),
    .c_in  (add_cin_s),
    .sum   (add_sum_s),
    .c_out (add_cout_s)
  );

  // Adder operand mux: |a| in IDLE, accumulate/trial-subtract in CALC, negate in FIX
  always_comb begin
    add_a_s   = {WIDTH{1'b0}};
    add_b_s   = {WIDTH{1'b0}};
    add_cin_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        add_a_s   = a[WIDTH-1] ? ~a : a;
        add_cin_s = a[WIDTH-1];
      end
      ST_CALC: begin
        if (is_div_s) begin
          // Adding raw negative b equals adding ~|b|+1, so the stored divisor never needs negating
          add_a_s   = rem_sh_s;
          add_b_s   = bneg_r ? y_r : ~y_r;
          add_cin_s = ~bneg_r;
        end else begin
          add_a_s   = acc_r;
          add_b_s   = x_r;
          add_cin_s = 1'b0;
        end
      end
      ST_FIX: begin
        add_a_s   = ~fix_src_s;
        add_cin_s = 1'b1;
      end
      default: begin
        add_a_s   = {WIDTH{1'b0}};
      end
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt  = state_r;
    op_nxt     = op_r;
    acc_nxt    = acc_r;
    x_nxt      = x_r;
    y_nxt      = y_r;
    cnt_nxt    = cnt_r;
    neg_nxt    = neg_r;
    bneg_nxt   = bneg_r;
    dz_nxt     = dz_r;
    result_nxt = result_r;
    busy_nxt   = busy_r;
    done_nxt   = 1'b0;
    dz_out_nxt = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy_nxt = 1'b0;
        if (start) begin
          op_nxt    = start_op_s;
          cnt_nxt   = {ITER_W{1'b0}};
          busy_nxt  = 1'b1;
          state_nxt = ST_CALC;
          y_nxt     = b;
          bneg_nxt  = b[WIDTH-1];
          if (start_op_s != OP_MUL) begin
            acc_nxt = {WIDTH{1'b0}};
            x_nxt   = add_sum_s;
            neg_nxt = (start_op_s == OP_DIV) ? (a[WIDTH-1] ^ b[WIDTH-1]) : a[WIDTH-1];
            dz_nxt  = (b == {WIDTH{1'b0}});
            if (b == {WIDTH{1'b0}}) begin
              acc_nxt   = a;
              neg_nxt   = 1'b0;
              state_nxt = ST_FIX;
            end else begin
`ifdef MULDIV_EARLY_EXIT_EN
              if (a == {WIDTH{1'b0}}) begin
                neg_nxt   = 1'b0;
                state_nxt = ST_FIX;
              end else begin
                state_nxt = ST_CALC;
              end
`else
              state_nxt = ST_CALC;
`endif
            end
          end else begin
            acc_nxt = {WIDTH{1'b0}};
            x_nxt   = a;
            neg_nxt = 1'b0;
            dz_nxt  = 1'b0;
`ifdef MULDIV_EARLY_EXIT_EN
            if (a == {WIDTH{1'b0}} || b == {WIDTH{1'b0}}) begin
              state_nxt = ST_FIX;
            end else begin
              state_nxt = ST_CALC;
            end
`else
            state_nxt = ST_CALC;
`endif
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_CALC: begin
        cnt_nxt = cnt_r + {{(ITER_W-1){1'b0}}, 1'b1};
        if (is_div_s) begin
          if (add_cout_s) begin
            acc_nxt = add_sum_s;
            x_nxt   = {x_r[WIDTH-2:0], 1'b1};
          end else begin
            acc_nxt = rem_sh_s;
            x_nxt   = {x_r[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_nxt = y_r[0] ? add_sum_s : acc_r;
          x_nxt   = {x_r[WIDTH-2:0], 1'b0};
          y_nxt   = {1'b0, y_r[WIDTH-1:1]};
        end
        if (cnt_r == ITER_W'(WIDTH - 1)) begin
          state_nxt = ST_FIX;
        end else begin
`ifdef MULDIV_EARLY_EXIT_EN
          if (!is_div_s && y_r[WIDTH-1:1] == {(WIDTH-1){1'b0}}) begin
            state_nxt = ST_FIX;
          end else begin
            state_nxt = ST_CALC;
          end
`else
          state_nxt = ST_CALC;
`endif
        end
      end
      ST_FIX: begin
        if (dz_r) begin
          result_nxt = (op_r == OP_DIV) ? DIV0_QUOT : acc_r;
        end else begin
          result_nxt = neg_r ? add_sum_s : fix_src_s;
        end
        done_nxt   = 1'b1;
        dz_out_nxt = dz_r;
        busy_nxt   = 1'b0;
        state_nxt  = ST_IDLE;
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      op_r     <= OP_MUL;
      acc_r    <= {WIDTH{1'b0}};
      x_r      <= {WIDTH{1'b0}};
      y_r      <= {WIDTH{1'b0}};
      cnt_r    <= {ITER_W{1'b0}};
      neg_r    <= 1'b0;
      bneg_r   <= 1'b0;
      dz_r     <= 1'b0;
      result_r <= {WIDTH{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      dz_out_r <= 1'b0;
    end else begin
      state_r  <= state_nxt;
      op_r     <= op_nxt;
      acc_r    <= acc_nxt;
      x_r      <= x_nxt;
      y_r      <= y_nxt;
      cnt_r    <= cnt_nxt;
      neg_r    <= neg_nxt;
      bneg_r   <= bneg_nxt;
      dz_r     <= dz_nxt;
      result_r <= result_nxt;
      busy_r   <= busy_nxt;
      done_r   <= done_nxt;
      dz_out_r <= dz_out_nxt;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign result      = result_r;
  assign div_by_zero = dz_out_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed cases plus randomized operations against a reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [31:0] a, b, result;
  logic        busy, done, div_by_zero;

  muldiv_unit #(.WIDTH(32), .ITER_W(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        dz;
    int          done_edge;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   busy_cnt = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: signed arithmetic on 64-bit values, latency in edges after the start edge
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t   e;
    longint sx, sy, q;
    logic [31:0] p;
`ifdef MULDIV_EARLY_EXIT_EN
    int n;
`endif
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.dz = 1'b0;
    e.lat = 33;
    e.done_edge = 0;
    if (o == 2'd1 || o == 2'd2) begin
      if (y == 32'd0) begin
        e.dz  = 1'b1;
        e.lat = 1;
        e.res = (o == 2'd1) ? 32'hFFFF_FFFF : x;
      end else begin
        q = (o == 2'd1) ? (sx / sy) : (sx % sy);
        e.res = q[31:0];
`ifdef MULDIV_EARLY_EXIT_EN
        if (x == 32'd0) e.lat = 1;
`endif
      end
    end else begin
      p = x * y;
      e.res = p;
`ifdef MULDIV_EARLY_EXIT_EN
      n = 0;
      for (int i = 0; i < 32; i++) if (y[i]) n = i + 1;
      e.lat = (x == 32'd0 || y == 32'd0) ? 1 : n + 1;
`endif
    end
    return e;
  endfunction

  // Caller is #1 after a posedge with the unit idle or in its done cycle
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    e = model(o, x, y);
    e.done_edge = cyc + e.lat;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops the scoreboard on every done pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: done=1 with no request outstanding, expected 0");
          end else begin
            e = sb.pop_front();
            check("result", result, e.res);
            check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
            check("done_edge", 32'(cyc), 32'(e.done_edge));
            check("busy_cycles", 32'(busy_cnt), 32'(e.lat));
            check("busy_at_done", {31'd0, busy}, 32'd0);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    reset = 1'b1; start = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_dz", {31'd0, div_by_zero}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    issue(2'd0, 32'd7, 32'hFFFF_FFFD);             wait_drain(100);
    issue(2'd1, 32'hFFFF_FFF9, 32'd2);             wait_drain(100);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2);             wait_drain(100);

    // Reset at the 10th edge of a MUL aborts it
    issue(2'd0, 32'd12345, 32'd678);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    sb.delete();
    @(posedge clk); #1 reset = 1'b0;
    issue(2'd0, 32'd6, 32'd7);                     wait_drain(100);

    issue(2'd1, 32'd100, 32'd0);                   wait_drain(100);
    issue(2'd2, 32'd100, 32'd0);                   wait_drain(100);
    issue(2'd1, 32'h8000_0000, 32'hFFFF_FFFF);     wait_drain(100);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);     wait_drain(100);
    issue(2'd3, 32'd9, 32'd5);                     wait_drain(100);

    // Start while busy is ignored; start in the done cycle is accepted
    issue(2'd1, 32'd50, 32'd7);
    repeat (3) @(posedge clk);
    #1 start = 1'b1; op = 2'd0; a = 32'd3; b = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    issue(2'd2, 32'd50, 32'd7);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_drain(100);

    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), rnd_val(), rnd_val());
      wait_drain(100);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
